// File: rtl/sram_access_arbiter.sv
// Two-port (AVR / SNES) arbiter sequencing external SRAM accesses as SETUP / ACCESS / HOLD.
// Define SRAM_ARB_ROUND_ROBIN_EN to alternate grants on ties; the default gives the AVR fixed priority.
module sram_access_arbiter #(
  parameter int DWIDTH      = 8,
  parameter int AWIDTH      = 19,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              avr_req,
  input  logic              avr_we,
  input  logic [AWIDTH-1:0] avr_addr,
  input  logic [DWIDTH-1:0] avr_wdata,
  output logic [DWIDTH-1:0] avr_rdata,
  output logic              avr_ack,
  input  logic              snes_req,
  input  logic              snes_we,
  input  logic [AWIDTH-1:0] snes_addr,
  input  logic [DWIDTH-1:0] snes_wdata,
  output logic [DWIDTH-1:0] snes_rdata,
  output logic              snes_ack,
  output logic [AWIDTH-1:0] sram_addr,
  output logic [DWIDTH-1:0] sram_wdata,
  input  logic [DWIDTH-1:0] sram_rdata,
  output logic              sram_dir,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy,
  output logic              grant_snes
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       cur_we;
  logic       pick_snes;

  // grant_snes still names the previous owner while IDLE, so it doubles as the round-robin pointer
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  assign pick_snes = snes_req && (!avr_req || !grant_snes);
`else
  assign pick_snes = snes_req && !avr_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      cur_we     <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dir   <= 1'b1;
      avr_ack    <= 1'b0;
      snes_ack   <= 1'b0;
      busy       <= 1'b0;
      avr_rdata  <= '0;
      snes_rdata <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      grant_snes <= 1'b1;
    end else begin
      avr_ack  <= 1'b0;
      snes_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (avr_req || snes_req) begin
            state      <= SETUP;
            busy       <= 1'b1;
            grant_snes <= pick_snes;
            cur_we     <= pick_snes ? snes_we : avr_we;
            sram_addr  <= pick_snes ? snes_addr : avr_addr;
            sram_wdata <= pick_snes ? snes_wdata : avr_wdata;
            sram_ce_n  <= 1'b0;
            sram_dir   <= pick_snes ? !snes_we : !avr_we;
          end
        end
        SETUP: begin
          state    <= ACCESS;
          wait_cnt <= WAIT_LOAD;
          if (cur_we) begin
            sram_we_n <= 1'b0;
          end else begin
            sram_oe_n <= 1'b0;
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state     <= HOLD;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            if (grant_snes) begin
              snes_ack <= 1'b1;
              if (!cur_we) snes_rdata <= sram_rdata;
            end else begin
              avr_ack <= 1'b1;
              if (!cur_we) avr_rdata <= sram_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        HOLD: begin
          // dir was held low through HOLD on writes so data outlives the we_n rise
          state     <= IDLE;
          busy      <= 1'b0;
          sram_ce_n <= 1'b1;
          sram_dir  <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench for sram_access_arbiter: directed table, multi-cycle corner sequences,
// a randomized run against a transaction-level model, and a zero-wait-state instance.
module tb_sram_access_arbiter;

  localparam int DW = 8;
  localparam int AW = 19;
  localparam int WC = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          avr_req = 1'b0;
  logic          avr_we = 1'b0;
  logic [AW-1:0] avr_addr = '0;
  logic [DW-1:0] avr_wdata = '0;
  logic [DW-1:0] avr_rdata;
  logic          avr_ack;
  logic          snes_req = 1'b0;
  logic          snes_we = 1'b0;
  logic [AW-1:0] snes_addr = '0;
  logic [DW-1:0] snes_wdata = '0;
  logic [DW-1:0] snes_rdata;
  logic          snes_ack;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          sram_dir, sram_ce_n, sram_oe_n, sram_we_n, busy, grant_snes;

  logic          z_snes_req = 1'b0;
  logic [AW-1:0] z_snes_addr = '0;
  logic [DW-1:0] z_avr_rdata, z_snes_rdata;
  logic          z_avr_ack, z_snes_ack;
  logic [AW-1:0] z_sram_addr;
  logic [DW-1:0] z_sram_wdata;
  logic          z_sram_dir, z_sram_ce_n, z_sram_oe_n, z_sram_we_n, z_busy, z_grant_snes;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [int];
  logic          last_snes;

  always #5 clk = ~clk;

  sram_access_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .avr_req(avr_req), .avr_we(avr_we), .avr_addr(avr_addr), .avr_wdata(avr_wdata),
    .avr_rdata(avr_rdata), .avr_ack(avr_ack),
    .snes_req(snes_req), .snes_we(snes_we), .snes_addr(snes_addr), .snes_wdata(snes_wdata),
    .snes_rdata(snes_rdata), .snes_ack(snes_ack),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_dir(sram_dir), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .busy(busy), .grant_snes(grant_snes)
  );

  sram_access_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .WAIT_CYCLES(0)) u_dut_zero (
    .clk(clk), .rst_n(rst_n),
    .avr_req(1'b0), .avr_we(1'b0), .avr_addr('0), .avr_wdata('0),
    .avr_rdata(z_avr_rdata), .avr_ack(z_avr_ack),
    .snes_req(z_snes_req), .snes_we(1'b0), .snes_addr(z_snes_addr), .snes_wdata('0),
    .snes_rdata(z_snes_rdata), .snes_ack(z_snes_ack),
    .sram_addr(z_sram_addr), .sram_wdata(z_sram_wdata), .sram_rdata(8'h3C),
    .sram_dir(z_sram_dir), .sram_ce_n(z_sram_ce_n), .sram_oe_n(z_sram_oe_n), .sram_we_n(z_sram_we_n),
    .busy(z_busy), .grant_snes(z_grant_snes)
  );

  // Behavioural asynchronous SRAM: drives data only while selected and output-enabled
  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : '0;

  always @(posedge sram_we_n) begin
    if (!sram_ce_n) sram_mem[sram_addr] <= sram_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return '0;
  endfunction

  // Arbitration rule: returns 1 when the SNES port should win this grant
  function automatic logic pick_model(input logic a, input logic s, input logic prev_snes);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    if (a && s) return !prev_snes;
`else
    if (a && s) return 1'b0;
`endif
    return s;
  endfunction

  logic avr_ack_prev = 1'b0;
  logic snes_ack_prev = 1'b0;

  // Continuous bus-safety and ack-width watch
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("bus_contention", {31'd0, (sram_dir == 1'b0 && sram_oe_n == 1'b0)}, 32'd0);
      checkOutput("avr_ack_width", {31'd0, (avr_ack && avr_ack_prev)}, 32'd0);
      checkOutput("snes_ack_width", {31'd0, (snes_ack && snes_ack_prev)}, 32'd0);
    end
    avr_ack_prev  <= avr_ack;
    snes_ack_prev <= snes_ack;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Runs one single-port access starting in an IDLE cycle; returns in the following IDLE cycle
  task automatic applyStimulus(input logic port_snes, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, output int cycles, output logic [1:0] acks,
                               output int we_low, output int oe_low, output int dir_low);
    if (port_snes) begin
      snes_we = we; snes_addr = addr; snes_wdata = wdata; snes_req = 1'b1;
    end else begin
      avr_we = we; avr_addr = addr; avr_wdata = wdata; avr_req = 1'b1;
    end
    cycles = 0; we_low = 0; oe_low = 0; dir_low = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
      if (!sram_dir) dir_low++;
    end while (!(avr_ack || snes_ack) && cycles < 40);
    acks = {snes_ack, avr_ack};
    avr_req = 1'b0;
    snes_req = 1'b0;
    if (we) ref_mem[int'(addr)] = wdata;
    last_snes = port_snes;
    @(negedge clk);
  endtask

  typedef struct {
    logic          snes;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int cyc, wl, ol, dl, n_acc;
    logic [1:0] ak;
    logic [DW-1:0] exp_avr, exp_snes;

    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = '0;
    last_snes = 1'b1;

    vecs[0] = '{1'b0, 1'b1, 19'h01234, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 19'h01234, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 19'h00010, 8'h3C, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 19'h00010, 8'h00, 8'h3C};
    vecs[4] = '{1'b0, 1'b0, 19'h7FFFF, 8'h00, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 19'h7FFFF, 8'hFF, 8'h00};
    vecs[6] = '{1'b1, 1'b0, 19'h7FFFF, 8'h00, 8'hFF};
    vecs[7] = '{1'b0, 1'b0, 19'h00010, 8'h00, 8'h3C};
    vecs[8] = '{1'b1, 1'b0, 19'h01234, 8'h00, 8'hA5};

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_ce_n", sram_ce_n, 1);
    checkOutput("rst_oe_n", sram_oe_n, 1);
    checkOutput("rst_we_n", sram_we_n, 1);
    checkOutput("rst_dir", sram_dir, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_acks", {avr_ack, snes_ack}, 0);
    checkOutput("rst_rdata", {avr_rdata, snes_rdata}, 0);
    checkOutput("rst_addr", sram_addr, 0);
    checkOutput("rst_wdata", sram_wdata, 0);
    checkOutput("rst_grant", grant_snes, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    exp_avr = '0;
    exp_snes = '0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].snes, vecs[i].we, vecs[i].addr, vecs[i].wdata, cyc, ak, wl, ol, dl);
      if (vecs[i].snes) exp_snes = vecs[i].exp_rdata; else exp_avr = vecs[i].exp_rdata;
      checkOutput($sformatf("tbl%0d_latency", i), cyc, WC + 3);
      checkOutput($sformatf("tbl%0d_ack", i), ak, vecs[i].snes ? 2'b10 : 2'b01);
      checkOutput($sformatf("tbl%0d_grant", i), grant_snes, vecs[i].snes);
      checkOutput($sformatf("tbl%0d_avr_rdata", i), avr_rdata, exp_avr);
      checkOutput($sformatf("tbl%0d_snes_rdata", i), snes_rdata, exp_snes);
      checkOutput($sformatf("tbl%0d_we_low", i), wl, vecs[i].we ? WC + 1 : 0);
      checkOutput($sformatf("tbl%0d_oe_low", i), ol, vecs[i].we ? 0 : WC + 1);
      checkOutput($sformatf("tbl%0d_dir_low", i), dl, vecs[i].we ? WC + 3 : 0);
      checkOutput($sformatf("tbl%0d_idle_busy", i), busy, 0);
    end

    // Both ports requesting continuously for four accesses
    begin
      logic exp_s;
      avr_we = 1'b0; avr_addr = 19'h01234; avr_req = 1'b1;
      snes_we = 1'b0; snes_addr = 19'h01234; snes_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
        exp_s = pick_model(1'b1, 1'b1, last_snes);
        cyc = 0;
        do begin
          @(negedge clk);
          cyc++;
        end while (!(avr_ack || snes_ack) && cyc < 40);
        checkOutput($sformatf("tie%0d_latency", k), cyc, k == 0 ? WC + 3 : WC + 4);
        checkOutput($sformatf("tie%0d_ack", k), {snes_ack, avr_ack}, exp_s ? 2'b10 : 2'b01);
        checkOutput($sformatf("tie%0d_rdata", k), exp_s ? snes_rdata : avr_rdata, 8'hA5);
        last_snes = exp_s;
      end
      avr_req = 1'b0;
      snes_req = 1'b0;
      @(negedge clk);
    end

    // SNES request raised one cycle into an AVR write
    begin
      int avr_at, snes_at;
      avr_at = 0; snes_at = 0;
      avr_we = 1'b1; avr_addr = 19'h00005; avr_wdata = 8'h77; avr_req = 1'b1;
      cyc = 0;
      while ((avr_at == 0 || snes_at == 0) && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) begin
          snes_we = 1'b0; snes_addr = 19'h00010; snes_req = 1'b1;
        end
        if (avr_ack && avr_at == 0) begin avr_at = cyc; avr_req = 1'b0; end
        if (snes_ack && snes_at == 0) begin snes_at = cyc; snes_req = 1'b0; end
      end
      ref_mem[5] = 8'h77;
      last_snes = 1'b1;
      checkOutput("late_avr_ack_cycle", avr_at, WC + 3);
      checkOutput("late_snes_ack_cycle", snes_at, 2 * WC + 7);
      checkOutput("late_snes_rdata", snes_rdata, 8'h3C);
      @(negedge clk);
    end

    // Reset asserted during the ACCESS phase of a write
    avr_we = 1'b1; avr_addr = 19'h00100; avr_wdata = 8'h5A; avr_req = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("abort_in_access", sram_we_n, 0);
    rst_n = 1'b0;
    avr_req = 1'b0;
    #1;
    checkOutput("abort_we_n", sram_we_n, 1);
    checkOutput("abort_oe_n", sram_oe_n, 1);
    checkOutput("abort_ce_n", sram_ce_n, 1);
    checkOutput("abort_dir", sram_dir, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_acks", {avr_ack, snes_ack}, 0);
    repeat (2) @(negedge clk);
    checkOutput("abort_no_late_ack", {avr_ack, snes_ack}, 0);
    rst_n = 1'b1;
    last_snes = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 19'h00101, 8'h66, cyc, ak, wl, ol, dl);
    checkOutput("post_rst_wr_latency", cyc, WC + 3);
    checkOutput("post_rst_wr_ack", ak, 2'b01);
    applyStimulus(1'b0, 1'b0, 19'h00101, 8'h00, cyc, ak, wl, ol, dl);
    checkOutput("post_rst_rd_ack", ak, 2'b01);
    checkOutput("post_rst_rd_data", avr_rdata, 8'h66);

    // Randomized run against the transaction-level model
    n_acc = 0;
    while (n_acc < 1000) begin
      int sel, n_serve;
      logic a_go, s_go, first_s, cur_s;
      sel = $urandom_range(1, 3);
      a_go = sel[0];
      s_go = sel[1];
      if (a_go) begin
        avr_we = 1'($urandom_range(0, 1)); avr_addr = AW'($urandom_range(0, 31));
        avr_wdata = DW'($urandom); avr_req = 1'b1;
      end
      if (s_go) begin
        snes_we = 1'($urandom_range(0, 1)); snes_addr = AW'($urandom_range(0, 31));
        snes_wdata = DW'($urandom); snes_req = 1'b1;
      end
      first_s = pick_model(a_go, s_go, last_snes);
      n_serve = int'(a_go) + int'(s_go);
      for (int k = 0; k < n_serve; k++) begin
        cur_s = (k == 0) ? first_s : !first_s;
        cyc = 0;
        do begin
          @(negedge clk);
          cyc++;
        end while (!(avr_ack || snes_ack) && cyc < 40);
        checkOutput("rand_latency", cyc, k == 0 ? WC + 3 : WC + 4);
        checkOutput("rand_ack_port", {snes_ack, avr_ack}, cur_s ? 2'b10 : 2'b01);
        checkOutput("rand_grant", grant_snes, cur_s);
        if (cur_s) begin
          if (snes_we) ref_mem[int'(snes_addr)] = snes_wdata;
          else checkOutput("rand_snes_rdata", snes_rdata, ref_read(snes_addr));
          snes_req = 1'b0;
        end else begin
          if (avr_we) ref_mem[int'(avr_addr)] = avr_wdata;
          else checkOutput("rand_avr_rdata", avr_rdata, ref_read(avr_addr));
          avr_req = 1'b0;
        end
        last_snes = cur_s;
        n_acc++;
      end
      @(negedge clk);
      checkOutput("rand_idle_busy", busy, 0);
    end

    // Zero wait-state instance: single SNES read
    begin
      logic saw_avr_ack;
      saw_avr_ack = 1'b0;
      z_snes_addr = 19'h2AAAA;
      z_snes_req = 1'b1;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (z_avr_ack) saw_avr_ack = 1'b1;
      end while (!z_snes_ack && cyc < 40);
      z_snes_req = 1'b0;
      checkOutput("w0_ack_cycle", cyc, 3);
      checkOutput("w0_snes_rdata", z_snes_rdata, 8'h3C);
      checkOutput("w0_avr_rdata", z_avr_rdata, 8'h00);
      checkOutput("w0_no_avr_ack", saw_avr_ack, 0);
      checkOutput("w0_grant", z_grant_snes, 1);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
